// File: rtl/hex_ascii_streamer_if.sv
// Valid/ready bundle for the hex ASCII streamer.
// Carries the load side (word in) and the character side (byte out).
interface hex_ascii_streamer_if #(
  parameter int W = 8
);
  logic [W-1:0] data_in;
  logic         load_valid;
  logic         load_ready;
  logic [7:0]   char_out;
  logic         char_valid;
  logic         char_ready;
  logic         busy;

  modport master (
    output data_in, load_valid, char_ready,
    input  load_ready, char_out, char_valid, busy
  );

  modport slave (
    input  data_in, load_valid, char_ready,
    output load_ready, char_out, char_valid, busy
  );
endinterface

// File: rtl/hex_ascii_streamer.sv
// Streams a binary word as uppercase ASCII hex digits, MSB nibble first,
// optionally followed by CR/LF.
module hex_ascii_streamer #(
  parameter int NIBBLES     = 2,
  parameter bit APPEND_CRLF = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  hex_ascii_streamer_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIGIT,
    S_CR,
    S_LF
  } state_t;

  state_t         r_state;
  state_t         w_state_nx;
  logic [W-1:0]   r_shift;
  logic [W-1:0]   w_shift_nx;
  logic [W-1:0]   w_shifted;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nx;
  logic [7:0]     r_char;
  logic [7:0]     w_char_nx;
  logic           r_valid;
  logic           w_valid_nx;
  logic           w_load_hs;
  logic           w_char_hs;

  function automatic logic [7:0] f_hex(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h37 + {4'h0, n};
  endfunction

  assign w_load_hs = bus.load_valid & (r_state == S_IDLE);
  assign w_char_hs = r_valid & bus.char_ready;
  assign w_shifted = r_shift << 4;

  always_comb begin
    w_state_nx = r_state;
    w_shift_nx = r_shift;
    w_cnt_nx   = r_cnt;
    w_char_nx  = r_char;
    w_valid_nx = r_valid;
    unique case (r_state)
      S_IDLE: begin
        if (w_load_hs) begin
          w_state_nx = S_DIGIT;
          w_shift_nx = bus.data_in;
          w_cnt_nx   = CW'(NIBBLES - 1);
          w_char_nx  = f_hex(bus.data_in[W-1 -: 4]);
          w_valid_nx = 1'b1;
        end
      end
      S_DIGIT: begin
        if (w_char_hs) begin
          if (r_cnt != '0) begin
            w_shift_nx = w_shifted;
            w_cnt_nx   = r_cnt - CW'(1);
            w_char_nx  = f_hex(w_shifted[W-1 -: 4]);
          end else if (APPEND_CRLF) begin
            w_state_nx = S_CR;
            w_char_nx  = 8'h0D;
          end else begin
            w_state_nx = S_IDLE;
            w_char_nx  = 8'h00;
            w_valid_nx = 1'b0;
          end
        end
      end
      S_CR: begin
        if (w_char_hs) begin
          w_state_nx = S_LF;
          w_char_nx  = 8'h0A;
        end
      end
      S_LF: begin
        if (w_char_hs) begin
          w_state_nx = S_IDLE;
          w_char_nx  = 8'h00;
          w_valid_nx = 1'b0;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_char_nx  = 8'h00;
        w_valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_char  <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_shift <= w_shift_nx;
      r_cnt   <= w_cnt_nx;
      r_char  <= w_char_nx;
      r_valid <= w_valid_nx;
    end
  end

  // Handshake flags come from registered state only.
  assign bus.load_ready = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.char_out   = r_char;
  assign bus.char_valid = r_valid;
endmodule
